// File: rtl/mpc_input_router_if.sv
// Pad-side and macro-side buses of the input router, grouped for port hookup.
// The slave modport is the router's view; the master modport is the pad/config driver's view.
interface mpc_input_router_if;
    logic [3:0]  configuration;
    logic [9:0]  IO_north_i;
    logic [13:0] IO_west_i;
    logic [13:0] IO_east_i;
    logic [9:0]  north_i_0, north_i_1, north_i_2, north_i_3;
    logic [13:0] west_i_0,  west_i_1,  west_i_2,  west_i_3;
    logic [13:0] east_i_0,  east_i_1,  east_i_2,  east_i_3;
    logic        cfg_busy;
    logic [3:0]  cfg_active;

    modport slave (
        input  configuration, IO_north_i, IO_west_i, IO_east_i,
        output north_i_0, north_i_1, north_i_2, north_i_3,
               west_i_0,  west_i_1,  west_i_2,  west_i_3,
               east_i_0,  east_i_1,  east_i_2,  east_i_3,
               cfg_busy, cfg_active
    );

    modport master (
        output configuration, IO_north_i, IO_west_i, IO_east_i,
        input  north_i_0, north_i_1, north_i_2, north_i_3,
               west_i_0,  west_i_1,  west_i_2,  west_i_3,
               east_i_0,  east_i_1,  east_i_2,  east_i_3,
               cfg_busy, cfg_active
    );
endinterface

// File: rtl/mpc_input_router.sv
// Synchronizes pad input buses and steers them to four macros per the applied configuration.
// Every configuration change passes through a zero-output quiesce window before it takes effect.
module mpc_input_router #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned QUIESCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mpc_input_router_if.slave  bus_if
);
    localparam int unsigned         CNT_W        = $clog2(QUIESCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST     = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [3:0]          CFG_DISABLED = 4'b0100;

    typedef enum logic {RUN, QUIESCE} state_e;

    logic [SYNC_STAGES-1:0][9:0]  north_sync_q;
    logic [SYNC_STAGES-1:0][13:0] west_sync_q;
    logic [SYNC_STAGES-1:0][13:0] east_sync_q;
    logic [3:0]                   cfg_meta_q, cfg_sync_q, cfg_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            north_sync_q <= '0;
            west_sync_q  <= '0;
            east_sync_q  <= '0;
            cfg_meta_q   <= '0;
            cfg_sync_q   <= '0;
            cfg_prev_q   <= '0;
        end else begin
            north_sync_q[0] <= bus_if.IO_north_i;
            west_sync_q[0]  <= bus_if.IO_west_i;
            east_sync_q[0]  <= bus_if.IO_east_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                north_sync_q[i] <= north_sync_q[i-1];
                west_sync_q[i]  <= west_sync_q[i-1];
                east_sync_q[i]  <= east_sync_q[i-1];
            end
            cfg_meta_q <= bus_if.configuration;
            cfg_sync_q <= cfg_meta_q;
            cfg_prev_q <= cfg_sync_q;
        end
    end

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             cfg_active_q;
    logic                   busy_q;
    logic [3:0][9:0]        north_q, north_d;
    logic [3:0][13:0]       west_q,  west_d;
    logic [3:0][13:0]       east_q,  east_d;
    logic [1:0]             home, partner;

    assign home    = cfg_active_q[1:0];
    assign partner = cfg_active_q[1:0] ^ 2'd1;

    // Split mode shares north with the horizontal neighbour, which also takes east.
    always_comb begin
        north_d = '0;
        west_d  = '0;
        east_d  = '0;
        if (!cfg_active_q[2]) begin
            north_d[home] = north_sync_q[SYNC_STAGES-1];
            west_d[home]  = west_sync_q[SYNC_STAGES-1];
            if (cfg_active_q[3]) begin
                north_d[partner] = north_sync_q[SYNC_STAGES-1];
                east_d[partner]  = east_sync_q[SYNC_STAGES-1];
            end else begin
                east_d[home] = east_sync_q[SYNC_STAGES-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= QUIESCE;
            cnt_q        <= '0;
            cfg_active_q <= CFG_DISABLED;
            busy_q       <= 1'b1;
            north_q      <= '0;
            west_q       <= '0;
            east_q       <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cfg_sync_q != cfg_active_q) begin
                        state_q <= QUIESCE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        north_q <= '0;
                        west_q  <= '0;
                        east_q  <= '0;
                    end else begin
                        north_q <= north_d;
                        west_q  <= west_d;
                        east_q  <= east_d;
                    end
                end
                QUIESCE: begin
                    north_q <= '0;
                    west_q  <= '0;
                    east_q  <= '0;
                    if (cfg_sync_q != cfg_prev_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cfg_active_q <= cfg_sync_q;
                        state_q      <= RUN;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= QUIESCE;
            endcase
        end
    end

    assign bus_if.north_i_0  = north_q[0];
    assign bus_if.north_i_1  = north_q[1];
    assign bus_if.north_i_2  = north_q[2];
    assign bus_if.north_i_3  = north_q[3];
    assign bus_if.west_i_0   = west_q[0];
    assign bus_if.west_i_1   = west_q[1];
    assign bus_if.west_i_2   = west_q[2];
    assign bus_if.west_i_3   = west_q[3];
    assign bus_if.east_i_0   = east_q[0];
    assign bus_if.east_i_1   = east_q[1];
    assign bus_if.east_i_2   = east_q[2];
    assign bus_if.east_i_3   = east_q[3];
    assign bus_if.cfg_busy   = busy_q;
    assign bus_if.cfg_active = cfg_active_q;
endmodule

// File: tb/tb_mpc_input_router.sv
// Directed-plus-random bench for mpc_input_router against a transaction-level routing model.
module tb_mpc_input_router;
    localparam int S  = 2;
    localparam int QC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mpc_input_router_if bi ();

    mpc_input_router #(.SYNC_STAGES(S), .QUIESCE_CYCLES(QC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bi)
    );

    logic [9:0]  dut_n [4];
    logic [13:0] dut_w [4];
    logic [13:0] dut_e [4];
    assign dut_n[0] = bi.north_i_0;  assign dut_n[1] = bi.north_i_1;
    assign dut_n[2] = bi.north_i_2;  assign dut_n[3] = bi.north_i_3;
    assign dut_w[0] = bi.west_i_0;   assign dut_w[1] = bi.west_i_1;
    assign dut_w[2] = bi.west_i_2;   assign dut_w[3] = bi.west_i_3;
    assign dut_e[0] = bi.east_i_0;   assign dut_e[1] = bi.east_i_1;
    assign dut_e[2] = bi.east_i_2;   assign dut_e[3] = bi.east_i_3;

    int tests = 0;
    int fails = 0;

    // Model state: the configuration the router should be applying and the pad values it should route.
    logic [3:0]  m_active;
    logic [9:0]  m_n;
    logic [13:0] m_w, m_e;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit any_out();
        bit r = 1'b0;
        for (int m = 0; m < 4; m++) r |= (|dut_n[m]) | (|dut_w[m]) | (|dut_e[m]);
        return r;
    endfunction

    // Recipients: west goes to the home macro; east to home (single) or its horizontal
    // neighbour (split); north to every macro that receives any bus.
    task automatic check_routes(input string tag, input logic [3:0] cfg);
        int  home, nbr;
        bit  split, gn, gw, ge;
        home  = int'(cfg[1:0]);
        nbr   = (home % 2 == 0) ? home + 1 : home - 1;
        split = cfg[3];
        for (int m = 0; m < 4; m++) begin
            gw = !cfg[2] && (m == home);
            ge = !cfg[2] && (split ? (m == nbr) : (m == home));
            gn = gw || ge;
            chk($sformatf("%s_north%0d", tag, m), 32'(dut_n[m]), gn ? 32'(m_n) : 32'd0);
            chk($sformatf("%s_west%0d",  tag, m), 32'(dut_w[m]), gw ? 32'(m_w) : 32'd0);
            chk($sformatf("%s_east%0d",  tag, m), 32'(dut_e[m]), ge ? 32'(m_e) : 32'd0);
        end
    endtask

    // Pads propagate to the macros after exactly S+1 edges.
    task automatic drive_pads(input logic [9:0] n, input logic [13:0] w, input logic [13:0] e);
        bi.IO_north_i = n;
        bi.IO_west_i  = w;
        bi.IO_east_i  = e;
        tick(S);
        check_routes("pad_hold", m_active);
        m_n = n; m_w = w; m_e = e;
        tick(1);
        check_routes("pad_lat", m_active);
    endtask

    // From RUN with stable pads: change the config and follow it through the quiesce window.
    task automatic apply_cfg(input logic [3:0] c);
        int n;
        bit bad;
        bi.configuration = c;
        tick(2);
        chk("pre_detect_busy", 32'(bi.cfg_busy), 32'd0);
        check_routes("pre_detect", m_active);
        tick(1);
        chk("busy_rise", 32'(bi.cfg_busy), 32'd1);
        chk("detect_zero", 32'(any_out()), 32'd0);
        n = 0; bad = 1'b0;
        while (bi.cfg_busy && n < 200) begin
            tick(1);
            n++;
            if (any_out()) bad = 1'b1;
        end
        chk("quiesce_len", n, QC);
        chk("quiesce_zero", 32'(bad), 32'd0);
        m_active = c;
        chk("cfg_active", 32'(bi.cfg_active), 32'(c));
        tick(1);
        check_routes("first_route", c);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},   32'(bi.cfg_busy),   32'd1);
        chk({tag, "_active"}, 32'(bi.cfg_active), 32'h4);
        chk({tag, "_zero"},   32'(any_out()),     32'd0);
    endtask

    // Release reset with configuration held; 2 sync edges + 1 compare edge + QC stable edges.
    task automatic release_and_run(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bi.cfg_busy && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_edges"}, n, 2 + 1 + QC);
        m_active = bi.configuration;
        chk({tag, "_active"}, 32'(bi.cfg_active), 32'(m_active));
        chk({tag, "_entry_zero"}, 32'(any_out()), 32'd0);
        tick(1);
        check_routes({tag, "_route"}, m_active);
    endtask

    function automatic logic [3:0] pick_cfg(input logic [3:0] avoid, input bit nonzero);
        logic [3:0] c;
        do c = 4'($urandom_range(nonzero ? 1 : 0, 15)); while (c == avoid);
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d fails %0d", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] x, y;
        int edges, n;
        bit bad;

        rst_n            = 1'b0;
        bi.configuration = 4'b0010;
        bi.IO_north_i    = '0;
        bi.IO_west_i     = 14'h1ABC;
        bi.IO_east_i     = '0;
        m_n = '0; m_w = 14'h1ABC; m_e = '0;
        m_active = 4'b0100;
        #23;
        check_reset_state("reset");
        release_and_run("boot");
        chk("boot_west2", 32'(bi.west_i_2), 32'h1ABC);

        drive_pads(10'h155, 14'h0F0F, 14'h3003);
        apply_cfg(4'b1001);
        chk("split_west1", 32'(bi.west_i_1), 32'h0F0F);
        chk("split_east0", 32'(bi.east_i_0), 32'h3003);
        apply_cfg(4'b0000);
        apply_cfg(4'b0011);

        for (int i = 0; i < 6; i++) begin
            apply_cfg(pick_cfg(m_active, 1'b0));
            drive_pads(10'($urandom), 14'($urandom), 14'($urandom));
        end

        drive_pads('1, '1, '1);
        if (m_active == 4'b0100) apply_cfg(4'b0000);
        apply_cfg(4'b0100);
        apply_cfg(4'b1110);

        apply_cfg(4'b1010);
        y = m_active;
        x = pick_cfg(y, 1'b0);
        edges = 0; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bi.configuration = (i % 2 == 0) ? x : y;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                edges++;
                if (edges >= 3 && (!bi.cfg_busy || any_out())) bad = 1'b1;
            end
        end
        chk("toggle_hold", 32'(bad), 32'd0);
        n = 0; bad = 1'b0;
        while (bi.cfg_busy && n < 100) begin
            tick(1);
            n++;
            if (any_out()) bad = 1'b1;
        end
        chk("toggle_release", n, 5);
        chk("toggle_zero", 32'(bad), 32'd0);
        chk("toggle_active", 32'(bi.cfg_active), 32'(y));
        tick(1);
        check_routes("toggle_route", y);

        bi.configuration = pick_cfg(m_active, 1'b1);
        tick(5);
        chk("midq_busy", 32'(bi.cfg_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midq_rst");
        tick(3);
        release_and_run("midq");
        drive_pads(10'($urandom), 14'($urandom), 14'($urandom));

        bi.IO_north_i = 10'($urandom);
        bi.IO_west_i  = 14'($urandom);
        bi.IO_east_i  = 14'($urandom);
        tick(1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midrun_rst");
        m_n = bi.IO_north_i; m_w = bi.IO_west_i; m_e = bi.IO_east_i;
        tick(2);
        release_and_run("midrun");
        drive_pads(10'($urandom), 14'($urandom), 14'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mpc_input_router.md
Name: mpc_input_router

Overview:
- Input-direction counterpart of the multi-project chip output selector.
- Takes pad input buses (north 10b, west 14b, east 14b), synchronizes them, and steers them to the four chip macros (_0.._3) according to the 4-bit configuration.
- Any configuration change passes through a quiesce window during which every macro input is held at 0. Macros never see a glitched or half-routed bus.

Parameters:
- SYNC_STAGES, 2, pad synchronizer depth; legal range 1..3.
- QUIESCE_CYCLES, 4, cycles the configuration must be stable in QUIESCE before it is applied; legal range 2..255.

Ports:
- clk  input  1  single block clock
- rst_n  input  1  asynchronous active-low reset
- configuration  input  4  routing select; asynchronous to clk, 2-flop synchronized internally
- IO_north_i  input  10  north pad inputs
- IO_west_i  input  14  west pad inputs
- IO_east_i  input  14  east pad inputs
- north_i_0..north_i_3  output  10 each  north inputs to macros 0..3
- west_i_0..west_i_3  output  14 each  west inputs to macros 0..3
- east_i_0..east_i_3  output  14 each  east inputs to macros 0..3
- cfg_busy  output  1  high while not in RUN
- cfg_active  output  4  configuration currently applied

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pad sync flops, all outputs, cfg sync flops and cfg_prev clear to 0;
  - cfg_active = 4'b0100 (disabled);
  - state = QUIESCE; cnt = 0; cfg_busy = 1.
- Data path:
  - pad -> SYNC_STAGES flops -> combinational route -> output register.
  - Pad change before edge k appears on macro outputs after edge k+SYNC_STAGES.
- Config path: configuration -> 2 flops -> cfg_sync; cfg_prev <= cfg_sync every edge.
- Routing, with A = cfg_active and k = A[1:0]:
  - A[2]=1: disabled; all macro outputs 0.
  - A[3]=0, A[2]=0 (single mode): macro k receives north, west and east buses; all other macros get 0.
  - A[3]=1, A[2]=0 (split mode):
    - west bus -> macro k;
    - east bus -> macro k^1 (horizontal neighbour);
    - north bus -> both k and k^1;
    - the other two macros get 0.
  - Output bits with no source are 0, never X.
- FSM, two states; the cnt width holds QUIESCE_CYCLES-1:
  - RUN:
    - cfg_busy=0; outputs registered from the routed data.
    - If cfg_sync != cfg_active: go to QUIESCE and set cnt=0. Outputs register 0 from that same edge, so the cycle after detection they are 0.
  - QUIESCE:
    - cfg_busy=1; output registers load 0 every edge.
    - If cfg_sync != cfg_prev: cnt <= 0.
    - Else if cnt == QUIESCE_CYCLES-1: cfg_active <= cfg_sync, go to RUN. First routed data appears at the next edge.
    - Else: cnt <= cnt+1.
  - A cfg_sync equal to the old cfg_active during QUIESCE is still re-applied through the full window. There is no shortcut.
- Simultaneous events:
  - A config change on the same edge as RUN entry is caught by the RUN comparison on the next edge.
  - Pad changes during QUIESCE are discarded at the output but still propagate through the synchronizers.
- Reset mid-operation: everything returns to reset values immediately, including mid-QUIESCE.
- No combinational path from any input to any output.

Test Plan:
- Reset, configuration=4'b0010, Q=4, S=2, IO_west_i=14'h1ABC:
  - cfg_busy falls within 2+1+4 edges of reset release and cfg_active=4'b0010;
  - next edge west_i_2=14'h1ABC; west_i_0/1/3 = 0; north_i_0 and east_i_0 = 0.
- Split mode 4'b1001, IO_west_i=14'h0F0F, IO_east_i=14'h3003, IO_north_i=10'h155 -> west_i_1=14'h0F0F, east_i_0=14'h3003, north_i_0=north_i_1=10'h155, macros 2/3 all 0.
- In RUN, switch 4'b0000 -> 4'b0011:
  - all outputs 0 from the edge after cfg_sync changes;
  - cfg_busy=1 for at least Q cycles;
  - afterwards only macro 3 is driven;
  - no cycle ever shows both macro 0 and macro 3 non-zero.
- Config toggled every 2 cycles for 20 cycles -> cfg_busy stays 1 and outputs stay 0 throughout; after toggling stops, busy clears after Q stable cycles.
- Config 4'b0100 and 4'b1110 -> every macro output 0 regardless of pad values (pads all ones).
- Assert rst_n mid-QUIESCE and mid-RUN with pad traffic -> outputs 0, cfg_active=4'b0100, cfg_busy=1 immediately without waiting for a clock edge; pad-to-output latency afterwards is exactly S+1 edges.
